// File: rtl/apb_fabric.sv
// APB decoder/mux: base/mask window decode, slot held for the whole transfer,
// error response for unmapped and timed-out accesses, sticky first-fault capture.
module apb_fabric #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLV    = 5,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE =
    {32'h2000_0000, 32'h0000_0000, 32'h1100_0000, 32'h1000_0000, 32'h8000_0000},
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK =
    {32'hFFFF_FFF8, 32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_F000, 32'h8000_0000},
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pdata,
  input  logic                          pwrite,
  input  logic [3:0]                    pstb,
  input  logic                          psel,
  input  logic                          penable,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pready,
  output logic                          perr,
  output logic [NUM_SLV-1:0]            s_sel,
  output logic [NUM_SLV-1:0]            s_enable,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]            s_ready,
  input  logic [NUM_SLV-1:0]            s_err,
  output logic [ADDR_WIDTH-1:0]         fault_addr,
  output logic                          fault_irq,
  input  logic                          fault_clr
);

  localparam int unsigned SLOT_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR} state_t;

  state_t              state, state_nxt;
  logic [SLOT_W-1:0]   slot_q, slot_nxt, dec_slot, cur_slot;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                dec_hit, fault_ev, rdy, err, timeout;
  logic [DATA_WIDTH-1:0] rd;

  // Write data, direction and strobes go straight from the master to the slaves.
  logic unused_fanout;
  assign unused_fanout = ^{pdata, pwrite, pstb};

  // Window decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    dec_hit  = 1'b0;
    dec_slot = '0;
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if ((paddr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_hit  = 1'b1;
        dec_slot = SLOT_W'(i);
      end
    end
  end

  // Next state and master/slave side steering.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_q;
    cnt_nxt   = cnt;
    prdata    = '0;
    pready    = 1'b0;
    perr      = 1'b0;
    s_sel     = '0;
    s_enable  = '0;
    fault_ev  = 1'b0;
    cur_slot  = (state == S_IDLE) ? dec_slot : slot_q;
    rd        = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (cur_slot == SLOT_W'(i)) rd = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
    rdy     = s_ready[cur_slot];
    err     = s_err[cur_slot];
    timeout = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

    unique case (state)
      S_IDLE: begin
        if (psel) begin
          slot_nxt = dec_slot;
          cnt_nxt  = '0;
          if (!dec_hit) begin
            // Enable without a seen setup phase gets its error right away.
            if (penable) begin
              pready   = 1'b1;
              perr     = 1'b1;
              fault_ev = 1'b1;
            end else begin
              state_nxt = S_ERR;
            end
          end else begin
            s_sel[dec_slot] = 1'b1;
            if (penable) begin
              s_enable[dec_slot] = 1'b1;
              pready             = rdy;
              perr               = err & rdy;
              prdata             = rdy ? rd : '0;
              if (!rdy) begin
                state_nxt = S_ACCESS;
                if (TIMEOUT != 0) cnt_nxt = CNT_W'(1);
              end
            end else begin
              state_nxt = S_ACCESS;
            end
          end
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (timeout) begin
          pready    = 1'b1;
          perr      = 1'b1;
          fault_ev  = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          s_sel[slot_q]    = 1'b1;
          s_enable[slot_q] = penable;
          pready           = rdy;
          perr             = err & rdy;
          prdata           = rdy ? rd : '0;
          if (penable && rdy) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (penable && (TIMEOUT != 0)) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_ERR: begin
        if (!psel) begin
          state_nxt = S_IDLE;
        end else if (penable) begin
          pready    = 1'b1;
          perr      = 1'b1;
          fault_ev  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Reset silences every combinational output immediately.
    if (!presetn) begin
      prdata   = '0;
      pready   = 1'b0;
      perr     = 1'b0;
      s_sel    = '0;
      s_enable = '0;
      fault_ev = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= S_IDLE;
      slot_q     <= '0;
      cnt        <= '0;
      fault_addr <= '0;
      fault_irq  <= 1'b0;
    end else begin
      state  <= state_nxt;
      slot_q <= slot_nxt;
      cnt    <= cnt_nxt;
      // A fault coinciding with a clear re-arms and captures in one step.
      if (fault_ev) begin
        if (!fault_irq || fault_clr) fault_addr <= paddr;
        fault_irq <= 1'b1;
      end else if (fault_clr) begin
        fault_irq <= 1'b0;
      end
    end
  end

endmodule
